// File: rtl/cpu_oci_debug_mem_seq_pkg.sv
// Shared definitions for the OCI debug memory sequencer.
// Holds the FSM state encoding, the jdo field positions, the JTAG command
// enum, the pending-slot payload type and the strobe decoder.
package cpu_oci_debug_mem_seq_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BE_W       = DATA_W / 8;
    localparam int unsigned JDO_W      = 38;
    localparam int unsigned ADDR_LSB   = 26;
    localparam int unsigned RD_BIT     = 35;
    localparam int unsigned CLRERR_BIT = 25;
    localparam int unsigned WDATA_MSB  = 34;
    localparam int unsigned WDATA_LSB  = 3;

    typedef enum logic [2:0] {
        IDLE,
        J_RD,
        J_RDCAP,
        J_WR,
        C_RD,
        C_RDCAP,
        C_WR
    } state_e;

    typedef enum logic [1:0] {
        J_NONE,
        J_LOAD,
        J_READ,
        J_WRITE
    } jcmd_e;

    // JTAG request: command plus every jdo bit the sequencer consumes (35:3)
    typedef struct packed {
        jcmd_e                       cmd;
        logic [RD_BIT:WDATA_LSB]     fld;
    } jreq_t;

    // Strobe priority: ocimem_b > ocimem_a > no_action_a
    function automatic jcmd_e decode_jtag(input logic a, input logic na, input logic b);
        if (b) begin
            return J_WRITE;
        end
        if (a) begin
            return J_LOAD;
        end
        if (na) begin
            return J_READ;
        end
        return J_NONE;
    endfunction

endpackage

// File: rtl/cpu_oci_debug_mem_seq_if.sv
// Bus bundle for the OCI debug memory sequencer.
// JTAG side : jdo, take_* strobes in; MonDReg, monitor_ready, monitor_error out.
// CPU side  : Avalon debug slave (address/read/write/writedata/byteenable in;
//             readdata/waitrequest out).
// Modports  : master = requester side, slave = sequencer side.
interface cpu_oci_debug_mem_seq_if
    import cpu_oci_debug_mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
);
    logic [JDO_W-1:0]  jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [DATA_W-1:0] MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic [BE_W-1:0]   avs_byteenable;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  MonDReg, monitor_ready, monitor_error,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output MonDReg, monitor_ready, monitor_error,
        output avs_readdata, avs_waitrequest
    );

endinterface

// File: rtl/cpu_oci_debug_mem_seq_ram.sv
// Single-port synchronous debug RAM, 2**ADDR_W x 32, byte-enabled writes.
// Ports: i_clk, i_rst (async, clears read register only), i_en, i_we,
//        i_addr, i_wdata, i_be in; o_rdata out (1-cycle read latency).
module cpu_oci_debug_ram
    import cpu_oci_debug_mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Byte-lane write
    always_ff @(posedge i_clk) begin
        if (i_en && i_we) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read; holds its value across write and idle cycles
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_oci_debug_mem_seq.sv
// sysclk-domain sequencer between the JTAG debug wrapper and the debug RAM.
// Runs single-word JTAG reads/writes and CPU Avalon accesses on a shared
// single-port RAM, arbitrated by one FSM.
// Ports: clk, reset (async, active-high), bus (slave modport of
//        cpu_oci_debug_mem_seq_if carrying the JTAG and Avalon signals).
// Params: ADDR_W (RAM word-address width), CPU_PRIO (0: JTAG wins a
//         same-cycle collision, 1: CPU wins).
module cpu_oci_debug_mem_seq
    import cpu_oci_debug_mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter bit          CPU_PRIO = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    cpu_oci_debug_mem_seq_if.slave  bus
);
    localparam logic [BE_W-1:0] BE_ALL = '1;

    state_e            r_state,   w_state_nxt;
    logic [ADDR_W-1:0] r_mon_a,   w_mon_a_nxt;
    logic [DATA_W-1:0] r_mon_d,   w_mon_d_nxt;
    logic              r_ready,   w_ready_nxt;
    logic              r_error,   w_error_nxt;
    logic              r_waitreq, w_waitreq_nxt;
    jreq_t             r_pend,    w_pend_nxt;
    logic [DATA_W-1:0] r_wdata,   w_wdata_nxt;

    jreq_t             w_jreq;
    jreq_t             w_jsel;
    logic              w_multi;
    logic              w_cpu_req;
    logic              w_jram;
    logic              w_cpu_first;

    logic              w_ram_en;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [BE_W-1:0]   w_ram_be;
    logic [DATA_W-1:0] w_ram_rdata;
    logic              w_unused;

    assign w_unused = ^{bus.jdo[JDO_W-1:RD_BIT+1], bus.jdo[WDATA_LSB-1:0]};

    cpu_oci_debug_ram #(.ADDR_W(ADDR_W)) u_ram (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .i_be    (w_ram_be),
        .o_rdata (w_ram_rdata)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_mon_a   <= '0;
            r_mon_d   <= '0;
            r_ready   <= 1'b1;
            r_error   <= 1'b0;
            r_waitreq <= 1'b1;
            r_pend    <= '{cmd: J_NONE, fld: '0};
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mon_a   <= w_mon_a_nxt;
            r_mon_d   <= w_mon_d_nxt;
            r_ready   <= w_ready_nxt;
            r_error   <= w_error_nxt;
            r_waitreq <= w_waitreq_nxt;
            r_pend    <= w_pend_nxt;
            r_wdata   <= w_wdata_nxt;
        end
    end

    // Next-state, arbitration and RAM port control
    always_comb begin
        w_state_nxt = r_state;
        w_mon_a_nxt = r_mon_a;
        w_mon_d_nxt = r_mon_d;
        w_ready_nxt = r_ready;
        w_error_nxt = r_error;
        w_pend_nxt  = r_pend;
        w_wdata_nxt = r_wdata;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_mon_a;
        w_ram_wdata = r_wdata;
        w_ram_be    = BE_ALL;

        w_jreq.cmd = decode_jtag(bus.take_action_ocimem_a, bus.take_no_action_ocimem_a,
                                 bus.take_action_ocimem_b);
        w_jreq.fld = bus.jdo[RD_BIT:WDATA_LSB];
        w_multi    = (bus.take_action_ocimem_a    & bus.take_no_action_ocimem_a) |
                     (bus.take_action_ocimem_a    & bus.take_action_ocimem_b)    |
                     (bus.take_no_action_ocimem_a & bus.take_action_ocimem_b);
        w_cpu_req  = bus.avs_read | bus.avs_write;

        // A pending JTAG loser is always served before anything new
        w_jsel      = (r_pend.cmd != J_NONE) ? r_pend : w_jreq;
        w_jram      = (w_jsel.cmd == J_READ) || (w_jsel.cmd == J_WRITE) ||
                      ((w_jsel.cmd == J_LOAD) && w_jsel.fld[RD_BIT]);
        w_cpu_first = w_cpu_req && (r_pend.cmd == J_NONE) && (CPU_PRIO || !w_jram);

        case (r_state)
            IDLE: begin
                if (w_cpu_first) begin
                    w_state_nxt = bus.avs_write ? C_WR : C_RD;
                    // JTAG lost the RAM: park it, op not yet complete
                    if (w_jram) begin
                        w_pend_nxt  = w_jsel;
                        w_ready_nxt = 1'b0;
                    end
                end else begin
                    w_pend_nxt.cmd = J_NONE;
                    if (w_jram) begin
                        w_ready_nxt = 1'b0;
                        w_state_nxt = (w_jsel.cmd == J_WRITE) ? J_WR : J_RD;
                    end
                end
                // Address load applies now unless the whole op was parked
                if ((w_jsel.cmd == J_LOAD) && !(w_cpu_first && w_jram)) begin
                    w_mon_a_nxt = w_jsel.fld[ADDR_LSB +: ADDR_W];
                    if (w_jsel.fld[CLRERR_BIT]) begin
                        w_error_nxt = 1'b0;
                    end
                end
                w_wdata_nxt = w_jsel.fld[WDATA_MSB:WDATA_LSB];
                // Fresh strobe while a parked op is being served is dropped
                if (w_multi || ((r_pend.cmd != J_NONE) && (w_jreq.cmd != J_NONE))) begin
                    w_error_nxt = 1'b1;
                end
            end
            J_RD: begin
                w_ram_en    = 1'b1;
                w_state_nxt = J_RDCAP;
            end
            J_RDCAP: begin
                w_mon_d_nxt = w_ram_rdata;
                w_mon_a_nxt = r_mon_a + ADDR_W'(1);
                w_ready_nxt = 1'b1;
                w_state_nxt = IDLE;
            end
            J_WR: begin
                w_ram_en    = 1'b1;
                w_ram_we    = 1'b1;
                w_mon_a_nxt = r_mon_a + ADDR_W'(1);
                w_ready_nxt = 1'b1;
                w_state_nxt = IDLE;
            end
            C_RD: begin
                w_ram_en    = 1'b1;
                w_ram_addr  = bus.avs_address;
                w_state_nxt = C_RDCAP;
            end
            C_RDCAP: begin
                w_state_nxt = IDLE;
            end
            C_WR: begin
                w_ram_en    = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_addr  = bus.avs_address;
                w_ram_wdata = bus.avs_writedata;
                w_ram_be    = bus.avs_byteenable;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Any JTAG strobe while busy is dropped and flagged
        if ((r_state != IDLE) && (w_jreq.cmd != J_NONE)) begin
            w_error_nxt = 1'b1;
        end

        w_waitreq_nxt = !((w_state_nxt == C_WR) || (w_state_nxt == C_RDCAP));
    end

    assign bus.MonDReg         = r_mon_d;
    assign bus.monitor_ready   = r_ready;
    assign bus.monitor_error   = r_error;
    assign bus.avs_waitrequest = r_waitreq;
    assign bus.avs_readdata    = w_ram_rdata;

endmodule

// File: tb/tb_cpu_oci_debug_mem_seq.sv
// Directed bench for cpu_oci_debug_mem_seq: two instances (CPU_PRIO=0 and 1)
// driven in lockstep, diverging only in the collision scenario.
module tb_cpu_oci_debug_mem_seq;
    import cpu_oci_debug_mem_seq_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    cpu_oci_debug_mem_seq_if #(.ADDR_W(8)) if0 ();
    cpu_oci_debug_mem_seq_if #(.ADDR_W(8)) if1 ();

    cpu_oci_debug_mem_seq #(.ADDR_W(8), .CPU_PRIO(1'b0)) u_dut0 (
        .clk   (clk),
        .reset (rst),
        .bus   (if0.slave)
    );

    cpu_oci_debug_mem_seq #(.ADDR_W(8), .CPU_PRIO(1'b1)) u_dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [31:0] o0, input logic [31:0] o1,
                        input logic [31:0] exp);
        chk({tag, "/p0"}, o0, exp);
        chk({tag, "/p1"}, o1, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd, input logic clr);
        logic [37:0] j;
        j        = '0;
        j[33:26] = addr;
        j[35]    = rd;
        j[25]    = clr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic set_j(input logic a, input logic na, input logic b, input logic [37:0] j);
        if0.take_action_ocimem_a = a;  if1.take_action_ocimem_a = a;
        if0.take_no_action_ocimem_a = na; if1.take_no_action_ocimem_a = na;
        if0.take_action_ocimem_b = b;  if1.take_action_ocimem_b = b;
        if0.jdo = j; if1.jdo = j;
    endtask

    task automatic set_c(input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [31:0] d, input logic [3:0] be);
        if0.avs_read = rd; if1.avs_read = rd;
        if0.avs_write = wr; if1.avs_write = wr;
        if0.avs_address = addr; if1.avs_address = addr;
        if0.avs_writedata = d; if1.avs_writedata = d;
        if0.avs_byteenable = be; if1.avs_byteenable = be;
    endtask

    // One-cycle JTAG strobe; returns in the cycle after the strobe
    task automatic jstrobe(input jcmd_e c, input logic [37:0] j);
        set_j(c == J_LOAD, c == J_READ, c == J_WRITE, j);
        tick();
        set_j(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] be);
        set_c(1'b0, 1'b1, addr, d, be);
        tick();
        tick();
        set_c(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic cpu_rd(input logic [7:0] addr, output logic [31:0] d0, output logic [31:0] d1);
        set_c(1'b1, 1'b0, addr, '0, '0);
        tick();
        tick();
        d0 = if0.avs_readdata;
        d1 = if1.avs_readdata;
        tick();
        set_c(1'b0, 1'b0, '0, '0, '0);
    endtask

    logic [31:0] d0, d1;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        set_j(1'b0, 1'b0, 1'b0, '0);
        set_c(1'b0, 1'b0, '0, '0, '0);
        repeat (3) tick();

        // Reset values
        chk2("rst_mond",  if0.MonDReg, if1.MonDReg, 32'h0);
        chk2("rst_ready", 32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h1);
        chk2("rst_err",   32'(if0.monitor_error), 32'(if1.monitor_error), 32'h0);
        chk2("rst_wait",  32'(if0.avs_waitrequest), 32'(if1.avs_waitrequest), 32'h1);
        chk2("rst_rdata", if0.avs_readdata, if1.avs_readdata, 32'h0);
        rst = 1'b0;
        tick();

        // Preload through the CPU port
        cpu_wr(8'h10, 32'hDEADBEEF, 4'hF);
        cpu_wr(8'h11, 32'hCAFEF00D, 4'hF);
        cpu_wr(8'h01, 32'h01010101, 4'hF);
        cpu_wr(8'h30, 32'h30303030, 4'hF);
        cpu_wr(8'h31, 32'h31313131, 4'hF);
        cpu_wr(8'h32, 32'h32323232, 4'hF);
        cpu_wr(8'h05, 32'h11223344, 4'hF);
        cpu_wr(8'h20, 32'h12345678, 4'hF);
        cpu_wr(8'h50, 32'h55AA55AA, 4'hF);

        // Load address 0x10 with read
        jstrobe(J_LOAD, jdo_a(8'h10, 1'b1, 1'b0));
        chk2("ld_rdy_n1", 32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h0);
        tick();
        chk2("ld_rdy_n2", 32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h0);
        tick();
        chk2("ld_rdy_n3", 32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h1);
        chk2("ld_mond",   if0.MonDReg, if1.MonDReg, 32'hDEADBEEF);
        jstrobe(J_READ, '0);
        tick();
        tick();
        chk2("ld_next", if0.MonDReg, if1.MonDReg, 32'hCAFEF00D);

        // Burst write across the top of the address space
        jstrobe(J_LOAD, jdo_a(8'hFE, 1'b0, 1'b0));
        chk2("bw_ld_rdy", 32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            jstrobe(J_WRITE, jdo_b(32'(i)));
            chk2("bw_rdy_n1", 32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h0);
            tick();
            chk2("bw_rdy_n2", 32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h1);
            tick();
        end
        cpu_rd(8'hFE, d0, d1);
        chk2("bw_fe", d0, d1, 32'h1);
        cpu_rd(8'hFF, d0, d1);
        chk2("bw_ff", d0, d1, 32'h2);
        cpu_rd(8'h00, d0, d1);
        chk2("bw_00", d0, d1, 32'h3);
        jstrobe(J_READ, '0);
        tick();
        tick();
        chk2("bw_wrap_a", if0.MonDReg, if1.MonDReg, 32'h01010101);

        // Busy drop: second read strobe one cycle later is ignored
        jstrobe(J_LOAD, jdo_a(8'h30, 1'b0, 1'b1));
        set_j(1'b0, 1'b1, 1'b0, '0);
        tick();
        tick();
        set_j(1'b0, 1'b0, 1'b0, '0);
        chk2("bd_err", 32'(if0.monitor_error), 32'(if1.monitor_error), 32'h1);
        tick();
        chk2("bd_mond", if0.MonDReg, if1.MonDReg, 32'h30303030);
        chk2("bd_rdy",  32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h1);
        jstrobe(J_READ, '0);
        tick();
        tick();
        chk2("bd_single", if0.MonDReg, if1.MonDReg, 32'h31313131);
        jstrobe(J_LOAD, jdo_a(8'h00, 1'b0, 1'b1));
        chk2("bd_clr",     32'(if0.monitor_error), 32'(if1.monitor_error), 32'h0);
        chk2("bd_clr_rdy", 32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h1);

        // Two strobes at once: ocimem_b wins, error flagged
        jstrobe(J_LOAD, jdo_a(8'h40, 1'b0, 1'b0));
        set_j(1'b0, 1'b1, 1'b1, jdo_b(32'h77));
        tick();
        set_j(1'b0, 1'b0, 1'b0, '0);
        chk2("ms_err", 32'(if0.monitor_error), 32'(if1.monitor_error), 32'h1);
        chk2("ms_rdy", 32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h0);
        tick();
        chk2("ms_rdy2", 32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h1);
        cpu_rd(8'h40, d0, d1);
        chk2("ms_wr", d0, d1, 32'h77);
        jstrobe(J_LOAD, jdo_a(8'h05, 1'b0, 1'b1));
        chk2("ms_clr", 32'(if0.monitor_error), 32'(if1.monitor_error), 32'h0);

        // Collision: CPU write and JTAG read of 0x05 in the same cycle
        set_c(1'b0, 1'b1, 8'h05, 32'hA5A5A5A5, 4'b0011);
        set_j(1'b0, 1'b1, 1'b0, '0);
        tick();
        set_j(1'b0, 1'b0, 1'b0, '0);
        chk("co_wait_n1/p0", 32'(if0.avs_waitrequest), 32'h1);
        chk("co_wait_n1/p1", 32'(if1.avs_waitrequest), 32'h0);
        chk2("co_rdy_n1", 32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h0);
        tick();
        if1.avs_write = 1'b0;
        chk("co_wait_n2/p0", 32'(if0.avs_waitrequest), 32'h1);
        tick();
        chk("co_rdy_n3/p0",  32'(if0.monitor_ready), 32'h1);
        chk("co_mond/p0",    if0.MonDReg, 32'h11223344);
        chk("co_wait_n3/p0", 32'(if0.avs_waitrequest), 32'h1);
        tick();
        chk("co_wait_n4/p0", 32'(if0.avs_waitrequest), 32'h0);
        tick();
        if0.avs_write = 1'b0;
        chk("co_rdy_n5/p1", 32'(if1.monitor_ready), 32'h1);
        chk("co_mond/p1",   if1.MonDReg, 32'h1122A5A5);
        chk2("co_err", 32'(if0.monitor_error), 32'(if1.monitor_error), 32'h0);
        cpu_rd(8'h05, d0, d1);
        chk2("co_ram", d0, d1, 32'h1122A5A5);

        // CPU read latency
        set_c(1'b1, 1'b0, 8'h20, '0, '0);
        tick();
        chk2("cr_wait_r1", 32'(if0.avs_waitrequest), 32'(if1.avs_waitrequest), 32'h1);
        tick();
        chk2("cr_wait_r2", 32'(if0.avs_waitrequest), 32'(if1.avs_waitrequest), 32'h0);
        chk2("cr_data",    if0.avs_readdata, if1.avs_readdata, 32'h12345678);
        tick();
        set_c(1'b0, 1'b0, '0, '0, '0);
        chk2("cr_wait_r3", 32'(if0.avs_waitrequest), 32'(if1.avs_waitrequest), 32'h1);

        // ocimem_a + no_action_a together: load wins (no read), error set
        set_j(1'b1, 1'b1, 1'b0, jdo_a(8'h50, 1'b0, 1'b0));
        tick();
        set_j(1'b0, 1'b0, 1'b0, '0);
        chk2("pa_err", 32'(if0.monitor_error), 32'(if1.monitor_error), 32'h1);
        chk2("pa_rdy", 32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h1);

        // Reset while in J_WR: the write must not land
        jstrobe(J_WRITE, jdo_b(32'h00000BAD));
        rst = 1'b1;
        #1;
        chk2("rw_rdy",  32'(if0.monitor_ready), 32'(if1.monitor_ready), 32'h1);
        chk2("rw_err",  32'(if0.monitor_error), 32'(if1.monitor_error), 32'h0);
        chk2("rw_wait", 32'(if0.avs_waitrequest), 32'(if1.avs_waitrequest), 32'h1);
        chk2("rw_mond", if0.MonDReg, if1.MonDReg, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        jstrobe(J_READ, '0);
        tick();
        tick();
        chk2("rw_mona0", if0.MonDReg, if1.MonDReg, 32'h3);
        cpu_rd(8'h50, d0, d1);
        chk2("rw_ram", d0, d1, 32'h55AA55AA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
